// File: rtl/rds_pkg.sv
// Shared constants and types for the RDS group encoder: offset words,
// CRC generator polynomial, field widths and the block / FSM enums.
package rds_pkg;

   localparam int INFO_BITS  = 16;
   localparam int CHECK_BITS = 10;

   // g(x) = x^10 + x^8 + x^7 + x^5 + x^4 + x^3 + 1
   localparam logic [10:0] CRC_POLY = 11'h5B9;

   localparam logic [9:0] OFS_A  = 10'h0FC;
   localparam logic [9:0] OFS_B  = 10'h198;
   localparam logic [9:0] OFS_C  = 10'h168;
   localparam logic [9:0] OFS_CP = 10'h350;
   localparam logic [9:0] OFS_D  = 10'h1B4;

   typedef enum logic [1:0] {
      BLK_A = 2'd0,
      BLK_B = 2'd1,
      BLK_C = 2'd2,
      BLK_D = 2'd3
   } blk_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_INFO  = 2'd1,
      ST_CHECK = 2'd2
   } state_e;

   // Offset word for a block; the third block uses C' when the B0 flag is set.
   function automatic logic [9:0] block_offset(input blk_e blk, input logic b0_flag);
      logic [9:0] ofs;
      ofs = OFS_A;
      case (blk)
         BLK_A:   ofs = OFS_A;
         BLK_B:   ofs = OFS_B;
         BLK_C:   ofs = b0_flag ? OFS_CP : OFS_C;
         BLK_D:   ofs = OFS_D;
         default: ofs = OFS_A;
      endcase
      return ofs;
   endfunction

endpackage

// File: rtl/rds_crc10.sv
// Serial CRC-10 LFSR for RDS checkwords. One message bit per shift_en,
// MSB first; rem holds the remainder of m(x)*x^10 / g(x).
module rds_crc10
   import rds_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       shift_en,
   input  logic       din,
   output logic [9:0] rem
);

   logic [9:0] rem_q;
   logic [9:0] rem_d;
   logic       fb;

   // Next remainder: clear wins, otherwise divide in one more message bit.
   always_comb begin
      rem_d = rem_q;
      fb    = din ^ rem_q[9];
      if (clear) begin
         rem_d = '0;
      end else if (shift_en) begin
         rem_d = {rem_q[8:0], 1'b0} ^ (fb ? CRC_POLY[9:0] : 10'h000);
      end
   end

   // Remainder register.
   always_ff @(posedge clk) begin
      if (reset) rem_q <= '0;
      else       rem_q <= rem_d;
   end

   assign rem = rem_q;

endmodule

// File: rtl/rds_group_encoder.sv
// RDS group encoder: serialises four 16-bit info words per group, appends
// CRC+offset checkwords, differentially encodes and emits a biphase level
// paced by a half-bit NCO. Once started the stream never pauses; the latched
// group repeats whenever no new group is offered at a group boundary.
//
// Handshake: group_valid is held by the source until group_ready pulses;
// group_ready is high for exactly the cycle in which group_data is captured
// (immediately from IDLE, otherwise in the bit_stb cycle of the next block-A
// bit 0). group_data is ignored in every other cycle.
module rds_group_encoder
   import rds_pkg::*;
#(
   parameter int unsigned       NCO_W     = 32,
   parameter logic [NCO_W-1:0]  PHASE_INC = NCO_W'(408022)
) (
   input  logic        clk_25m,
   input  logic        reset,
   input  logic [63:0] group_data,
   input  logic        group_valid,
   output logic        group_ready,
   output logic        active,
   output logic        half_stb,
   output logic        bit_stb,
   output logic        diff_bit,
   output logic        biphase_out
);

   state_e             state_q, state_d;
   blk_e               blk_q, blk_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [63:0]        grp_q, grp_d;
   logic               active_q, active_d;
   logic               boundary_q, boundary_d;
   logic [NCO_W-1:0]   acc_q, acc_d;
   logic               half_q, half_d;
   logic               half_sel_q, half_sel_d;
   logic               diff_q, diff_d;
   logic               bip_q, bip_d;

   logic               bit_stb_w;
   logic               accept_idle;
   logic               accept_run;
   logic [15:0]        word;
   logic [15:0]        info_sh;
   logic [9:0]         chk_word;
   logic [9:0]         chk_sh;
   logic               cur_bit;
   logic               crc_clear;
   logic               crc_shift;
   logic [9:0]         crc_rem;

   // half_sel_q low means the next half-bit boundary opens a new bit.
   assign bit_stb_w   = half_q & ~half_sel_q;
   assign accept_idle = (state_q == ST_IDLE) & group_valid;
   assign accept_run  = bit_stb_w & boundary_q & group_valid & (state_q == ST_INFO);

   // Half-bit NCO; the carry becomes half_stb one cycle later.
   always_comb begin
      acc_d      = acc_q;
      half_d     = 1'b0;
      half_sel_d = half_q ? ~half_sel_q : half_sel_q;
      if (active_q) begin
         {half_d, acc_d} = {1'b0, acc_q} + {1'b0, PHASE_INC};
      end
   end

   // Current transmitted bit: info word MSB first, then CRC ^ offset MSB first.
   always_comb begin
      case (blk_q)
         BLK_A:   word = accept_run ? group_data[63:48] : grp_q[63:48];
         BLK_B:   word = grp_q[47:32];
         BLK_C:   word = grp_q[31:16];
         BLK_D:   word = grp_q[15:0];
         default: word = grp_q[63:48];
      endcase
      info_sh  = word << cnt_q;
      chk_word = crc_rem ^ block_offset(blk_q, grp_q[43]);
      chk_sh   = chk_word << cnt_q;
      cur_bit  = (state_q == ST_CHECK) ? chk_sh[9] : info_sh[15];
   end

   // Differential encoder and biphase level, updated only on half-bit ticks.
   always_comb begin
      diff_d = diff_q;
      bip_d  = bip_q;
      if (bit_stb_w) begin
         diff_d = diff_q ^ cur_bit;
         bip_d  = diff_q ^ cur_bit;
      end else if (half_q) begin
         bip_d  = ~diff_q;
      end
   end

   // Sequencer: IDLE until the first group, then INFO/CHECK per block forever.
   always_comb begin
      state_d    = state_q;
      blk_d      = blk_q;
      cnt_d      = cnt_q;
      grp_d      = grp_q;
      active_d   = active_q;
      boundary_d = boundary_q;
      crc_clear  = 1'b0;
      crc_shift  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (group_valid) begin
               grp_d      = group_data;
               active_d   = 1'b1;
               state_d    = ST_INFO;
               blk_d      = BLK_A;
               cnt_d      = 4'd0;
               boundary_d = 1'b0;
               crc_clear  = 1'b1;
            end
         end
         ST_INFO: begin
            if (bit_stb_w) begin
               crc_shift  = 1'b1;
               boundary_d = 1'b0;
               if (accept_run) grp_d = group_data;
               if (cnt_q == 4'(INFO_BITS - 1)) begin
                  state_d = ST_CHECK;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d   = cnt_q + 4'd1;
               end
            end
         end
         ST_CHECK: begin
            if (bit_stb_w) begin
               if (cnt_q == 4'(CHECK_BITS - 1)) begin
                  state_d    = ST_INFO;
                  cnt_d      = 4'd0;
                  blk_d      = blk_e'(blk_q + 2'd1);
                  crc_clear  = 1'b1;
                  boundary_d = (blk_q == BLK_D);
               end else begin
                  cnt_d      = cnt_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset discards any group in flight.
   always_ff @(posedge clk_25m) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         blk_q      <= BLK_A;
         cnt_q      <= 4'd0;
         grp_q      <= '0;
         active_q   <= 1'b0;
         boundary_q <= 1'b0;
         acc_q      <= '0;
         half_q     <= 1'b0;
         half_sel_q <= 1'b0;
         diff_q     <= 1'b0;
         bip_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         blk_q      <= blk_d;
         cnt_q      <= cnt_d;
         grp_q      <= grp_d;
         active_q   <= active_d;
         boundary_q <= boundary_d;
         acc_q      <= acc_d;
         half_q     <= half_d;
         half_sel_q <= half_sel_d;
         diff_q     <= diff_d;
         bip_q      <= bip_d;
      end
   end

   rds_crc10 u_crc (
      .clk      (clk_25m),
      .reset    (reset),
      .clear    (crc_clear),
      .shift_en (crc_shift),
      .din      (cur_bit),
      .rem      (crc_rem)
   );

   assign group_ready = (accept_idle | accept_run) & ~reset;
   assign active      = active_q;
   assign half_stb    = half_q;
   assign bit_stb     = bit_stb_w;
   assign diff_bit    = diff_q;
   assign biphase_out = bip_q;

endmodule

// File: tb/tb_rds_group_encoder.sv
// Bench for rds_group_encoder: random groups, repeats, mid-stream reset.
// Expected half-bit levels come from a polynomial-division reference model.
module tb_rds_group_encoder;

   localparam logic [31:0] TB_INC = 32'd572662306;  // ~7.5 clocks per half bit
   localparam int          NG     = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] group_data;
   logic        group_valid;
   logic        group_ready;
   logic        active;
   logic        half_stb;
   logic        bit_stb;
   logic        diff_bit;
   logic        biphase_out;

   logic [1:0]  exp_q[$];   // {diff_bit, biphase_out} per half bit
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_ready = 0;
   int          n_new = 0;
   int          cyc = 0;
   int          hs_idx = 0;
   int          last_hs = -1;
   bit          pend = 1'b0;
   logic        model_d;
   longint      sp_lo;

   logic [63:0] sched_data [NG];
   bit          sched_new  [NG];

   rds_group_encoder #(.NCO_W(32), .PHASE_INC(TB_INC)) dut (
      .clk_25m     (clk),
      .reset       (reset),
      .group_data  (group_data),
      .group_valid (group_valid),
      .group_ready (group_ready),
      .active      (active),
      .half_stb    (half_stb),
      .bit_stb     (bit_stb),
      .diff_bit    (diff_bit),
      .biphase_out (biphase_out)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tfail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Reference CRC: remainder of m(x)*x^10 modulo g(x) by long division.
   function automatic logic [9:0] ref_crc(input logic [15:0] m);
      logic [25:0] v;
      logic [25:0] g;
      v = {m, 10'h000};
      g = 26'h5B9;
      for (int i = 25; i >= 10; i--)
         if (v[i]) v = v ^ (g << (i - 10));
      return v[9:0];
   endfunction

   // Push the expected 208 half-bit levels of one group.
   task automatic push_group(input logic [63:0] g);
      logic [15:0] w;
      logic [9:0]  ofs;
      logic [25:0] bits;
      for (int b = 0; b < 4; b++) begin
         w = g[63 - 16*b -: 16];
         case (b)
            0:       ofs = 10'h0FC;
            1:       ofs = 10'h198;
            2:       ofs = g[43] ? 10'h350 : 10'h168;
            default: ofs = 10'h1B4;
         endcase
         bits = {w, ref_crc(w) ^ ofs};
         for (int i = 25; i >= 0; i--) begin
            model_d = model_d ^ bits[i];
            exp_q.push_back({model_d, model_d});
            exp_q.push_back({model_d, ~model_d});
         end
      end
   endtask

   // Driver timing point: just after the active edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_bits(input int n);
      int seen;
      int left;
      seen = 0;
      left = n * 20 + 100;
      while (seen < n && left > 0) begin
         step();
         if (bit_stb) seen++;
         left--;
      end
      if (seen < n) tfail("wait_bits");
   endtask

   // Offer a group and hold valid until the accept pulse, then drop it.
   task automatic offer(input logic [63:0] g);
      bit found;
      int k;
      group_data  = g;
      group_valid = 1'b1;
      found = 1'b0;
      k = 0;
      while (!found && k < 3000) begin
         #1;
         if (group_ready) found = 1'b1;
         else begin
            step();
            k++;
         end
      end
      if (!found) tfail("group_ready");
      step();
      group_valid = 1'b0;
      group_data  = {$urandom, $urandom};
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_group_ready"}, 32'(group_ready), 32'd0);
      chk({tag, "_active"},      32'(active),      32'd0);
      chk({tag, "_half_stb"},    32'(half_stb),    32'd0);
      chk({tag, "_bit_stb"},     32'(bit_stb),     32'd0);
      chk({tag, "_diff_bit"},    32'(diff_bit),    32'd0);
      chk({tag, "_biphase"},     32'(biphase_out), 32'd0);
   endtask

   // Monitor: pops one expectation per half bit, checks pacing and accepts.
   always @(negedge clk) begin
      logic [1:0] e;
      int         sp;
      if (reset) begin
         pend    = 1'b0;
         hs_idx  = 0;
         last_hs = -1;
         exp_q.delete();
      end else begin
         if (pend) begin
            pend = 1'b0;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL stream_extra: half %0d got %b%b, none expected", hs_idx, diff_bit, biphase_out);
            end else begin
               e = exp_q.pop_front();
               chk("stream_half", 32'({diff_bit, biphase_out}), 32'(e));
            end
         end
         if (group_ready) begin
            n_ready++;
            if (active) chk("ready_align", 32'({bit_stb, (hs_idx % 208) == 0}), 32'd3);
         end
         if (half_stb) begin
            if (last_hs >= 0) begin
               sp = cyc - last_hs;
               n_cmp++;
               if (!(sp == sp_lo || sp == sp_lo + 1)) begin
                  n_err++;
                  $display("FAIL half_spacing: got %0d expected %0d or %0d", sp, sp_lo, sp_lo + 1);
               end
            end
            chk("bit_stb_phase", 32'(bit_stb), 32'((hs_idx % 2) == 0));
            chk("active_run", 32'(active), 32'd1);
            last_hs = cyc;
            hs_idx++;
            pend = 1'b1;
         end
      end
   end

   // Stimulus.
   initial begin
      int r;
      int left;
      sp_lo       = 64'h1_0000_0000 / longint'(TB_INC);
      reset       = 1'b1;
      group_valid = 1'b0;
      group_data  = '0;
      model_d     = 1'b0;
      repeat (4) step();
      check_idle_outputs("reset");
      reset = 1'b0;
      step();

      // Group schedule: directed cases first, then random with repeats.
      sched_data[0] = 64'h0;                          sched_new[0] = 1'b1;
      sched_data[1] = {16'h0001, 48'h0};              sched_new[1] = 1'b1;
      sched_data[2] = {$urandom, $urandom} | (64'h1 << 43); sched_new[2] = 1'b1;
      sched_data[3] = {$urandom, $urandom} & ~(64'h1 << 43); sched_new[3] = 1'b1;
      sched_data[4] = sched_data[3];                  sched_new[4] = 1'b0;
      sched_data[5] = {$urandom, $urandom};           sched_new[5] = 1'b1;
      sched_data[6] = sched_data[5];                  sched_new[6] = 1'b0;
      sched_data[7] = {$urandom, $urandom};           sched_new[7] = 1'b1;
      sched_data[8] = {$urandom, $urandom};           sched_new[8] = 1'b1;
      sched_data[9] = sched_data[8];                  sched_new[9] = 1'b0;
      for (int k = 0; k < NG; k++) begin
         push_group(sched_data[k]);
         if (sched_new[k]) n_new++;
      end

      offer(sched_data[0]);
      wait_bits(1);
      for (int k = 1; k < NG; k++) begin
         if (sched_new[k]) begin
            r = $urandom_range(1, 90);
            wait_bits(r);
            offer(sched_data[k]);
         end else begin
            wait_bits(104);
         end
      end

      // Reset in the middle of block B of the final repeated group.
      wait_bits(40);
      repeat (3) step();
      reset = 1'b1;
      step();
      check_idle_outputs("midreset");
      step();
      reset = 1'b0;
      model_d = 1'b0;
      push_group(sched_data[8]);
      n_new++;
      offer(sched_data[8]);

      left = 4000;
      while (exp_q.size() != 0 && left > 0) begin
         step();
         left--;
      end
      if (exp_q.size() != 0) tfail("stream_drain");
      chk("ready_count", 32'(n_ready), 32'(n_new));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
